cmd_frame_loader: RTL and testbench

Host-command front end for the matrix-vector processor array. Parses byte frames from the UART receiver, configures matrix size N, routes matrix rows into the per-processor operand FIFOs and vector elements into the shared vector FIFO, and issues the one-cycle `start` to the processor sequencer. Sits between the UART RX and the FIFO/processor cluster; it is the only writer of those FIFOs.

---
 rtl/processor_pkg.sv | 48 ++++
 rtl/cmd_frame_loader_if.sv | 30 +++
 rtl/row_col_counter.sv | 36 +++
 rtl/cmd_frame_loader.sv | 218 +++++++++++++++++++++
 tb/tb_cmd_frame_loader.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/processor_pkg.sv
// Shared types and constants for the host-command frame loader:
// parser states, framing bytes, command codes and error causes.
package processor_pkg;

    typedef logic [3:0] nibble_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_CMD,
        ST_PAYLOAD,
        ST_TAIL
    } state_t;

    typedef enum logic [1:0] {
        ERR_LEN   = 2'd0,
        ERR_CMD   = 2'd1,
        ERR_TAIL  = 2'd2,
        ERR_STATE = 2'd3
    } err_t;

    localparam logic [7:0] HDR  = 8'hFE;
    localparam logic [7:0] TAIL = 8'hEF;

    localparam logic [7:0] CMD_SET_N = 8'h01;
    localparam logic [7:0] CMD_VEC   = 8'h02;
    localparam logic [7:0] CMD_START = 8'h03;
    localparam logic [7:0] CMD_MAT   = 8'h04;

    function automatic logic cmd_known(input logic [7:0] cmd);
        return (cmd == CMD_SET_N) || (cmd == CMD_VEC) ||
               (cmd == CMD_START) || (cmd == CMD_MAT);
    endfunction

    // Length byte each command must carry (CMD byte plus payload).
    function automatic logic [7:0] req_len(input logic [7:0] cmd, input nibble_t n);
        logic [7:0] n8;
        n8 = {4'd0, n};
        case (cmd)
            CMD_SET_N: return 8'd2;
            CMD_VEC:   return n8 + 8'd1;
            CMD_START: return 8'd1;
            CMD_MAT:   return n8 * n8 + 8'd1;
            default:   return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/cmd_frame_loader_if.sv
// Byte-stream input and FIFO/sequencer control bundle of the frame loader.
interface cmd_frame_loader_if #(
    parameter int MAX_N = 8,
    parameter int DW    = 8
);
    logic [DW-1:0]    rx_data;
    logic             rx_valid;
    logic             busy;
    logic [3:0]       n_cfg;
    logic [DW-1:0]    push_data;
    logic [MAX_N-1:0] mat_push;
    logic             vec_push;
    logic             fifo_clr;
    logic             start;
    logic             frame_ok;
    logic             err;
    logic [1:0]       err_code;

    modport master (
        output rx_data, rx_valid, busy,
        input  n_cfg, push_data, mat_push, vec_push, fifo_clr,
               start, frame_ok, err, err_code
    );

    modport slave (
        input  rx_data, rx_valid, busy,
        output n_cfg, push_data, mat_push, vec_push, fifo_clr,
               start, frame_ok, err, err_code
    );
endinterface

// File: rtl/row_col_counter.sv
// Row-major position counter over an N x N matrix; last flags the final cell.
module row_col_counter
    import processor_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    clr,
    input  logic    inc,
    input  nibble_t n,
    output nibble_t row,
    output nibble_t col,
    output logic    last
);
    nibble_t n_m1;
    assign n_m1 = n - 4'd1;
    assign last = (row == n_m1) && (col == n_m1);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col == n_m1) begin
                col <= '0;
                row <= row + 4'd1;
            end else begin
                col <= col + 4'd1;
            end
        end
    end
endmodule

// File: rtl/cmd_frame_loader.sv
// Host-command frame parser: configures N, routes payload bytes into the
// operand FIFOs and issues start to the processor sequencer.
module cmd_frame_loader
    import processor_pkg::*;
#(
    parameter int MAX_N   = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 50000
) (
    input logic              clk,
    input logic              rst,
    cmd_frame_loader_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [MAX_N-1:0] ROW0 = MAX_N'(1);

    state_t           state_q, state_d;
    logic [7:0]       len_q, len_d, cmd_q, cmd_d, cnt_q, cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    nibble_t          n_q, n_d, n_pend_q, n_pend_d;
    logic [DW-1:0]    data_q, data_d;
    logic [MAX_N-1:0] mat_q, mat_d;
    logic             vec_q, vec_d, clr_q, clr_d, start_q, start_d;
    logic             ok_q, ok_d, err_q, err_d;
    err_t             code_q, code_d, fail_code;
    logic             mat_ld_q, mat_ld_d, vec_ld_q, vec_ld_d, pushed_q, pushed_d;
    logic             fail, tmo_hit, rc_clr, rc_inc, rc_last, done;
    nibble_t          rc_row, rc_col;
    logic [7:0]       rx_byte;

    assign rx_byte = bus.rx_data[7:0];

    row_col_counter u_rc (
        .clk  (clk),
        .rst  (rst),
        .clr  (rc_clr),
        .inc  (rc_inc),
        .n    (n_q),
        .row  (rc_row),
        .col  (rc_col),
        .last (rc_last)
    );

    assign tmo_hit = !bus.rx_valid && (state_q != ST_IDLE) && (tmo_q == TW'(TIMEOUT - 1));
    assign done    = (cmd_q == CMD_MAT) ? rc_last : (cnt_q == 8'd1);

    // NOTE: every variable gets a default first so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cmd_d     = cmd_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        n_pend_d  = n_pend_q;
        data_d    = '0;
        mat_d     = '0;
        vec_d     = 1'b0;
        clr_d     = 1'b0;
        start_d   = 1'b0;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;
        mat_ld_d  = mat_ld_q;
        vec_ld_d  = vec_ld_q;
        pushed_d  = pushed_q;
        fail      = 1'b0;
        fail_code = ERR_LEN;
        rc_clr    = 1'b0;
        rc_inc    = 1'b0;
        tmo_d     = (bus.rx_valid || state_q == ST_IDLE) ? '0 : tmo_q + TW'(1);

        if (bus.rx_valid) begin
            case (state_q)
                ST_IDLE: if (rx_byte == HDR) state_d = ST_LEN;
                ST_LEN: begin
                    len_d   = rx_byte;
                    state_d = ST_CMD;
                end
                ST_CMD: begin
                    cmd_d    = rx_byte;
                    cnt_d    = len_q - 8'd1;
                    pushed_d = 1'b0;
                    rc_clr   = 1'b1;
                    if (!cmd_known(rx_byte)) begin
                        fail = 1'b1; fail_code = ERR_CMD;
                    end else if (len_q != req_len(rx_byte, n_q)) begin
                        fail = 1'b1; fail_code = ERR_LEN;
                    end else if (bus.busy && rx_byte != CMD_SET_N) begin
                        fail = 1'b1; fail_code = ERR_STATE;
                    end else begin
                        state_d = (len_q == 8'd1) ? ST_TAIL : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    cnt_d = cnt_q - 8'd1;
                    if (done) state_d = ST_TAIL;
                    case (cmd_q)
                        CMD_SET_N: begin
                            if (rx_byte < 8'd2 || rx_byte > 8'(MAX_N)) begin
                                fail = 1'b1; fail_code = ERR_LEN;
                            end else begin
                                n_pend_d = rx_byte[3:0];
                            end
                        end
                        CMD_VEC: begin
                            vec_d    = 1'b1;
                            data_d   = bus.rx_data;
                            pushed_d = 1'b1;
                        end
                        default: begin
                            mat_d    = ROW0 << rc_row;
                            data_d   = bus.rx_data;
                            rc_inc   = 1'b1;
                            pushed_d = 1'b1;
                        end
                    endcase
                end
                default: begin
                    state_d  = ST_IDLE;
                    pushed_d = 1'b0;
                    if (rx_byte != TAIL) begin
                        fail = 1'b1; fail_code = ERR_TAIL;
                    end else begin
                        case (cmd_q)
                            CMD_SET_N: begin
                                n_d = n_pend_q; ok_d = 1'b1;
                                mat_ld_d = 1'b0; vec_ld_d = 1'b0;
                            end
                            CMD_VEC: begin
                                vec_ld_d = 1'b1; ok_d = 1'b1;
                            end
                            CMD_MAT: begin
                                mat_ld_d = 1'b1; ok_d = 1'b1;
                            end
                            default: begin
                                if (mat_ld_q && vec_ld_q && !bus.busy) begin
                                    start_d = 1'b1; ok_d = 1'b1;
                                    mat_ld_d = 1'b0; vec_ld_d = 1'b0;
                                end else begin
                                    fail = 1'b1; fail_code = ERR_STATE;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end else if (tmo_hit) begin
            fail = 1'b1; fail_code = ERR_TAIL;
        end

        // Any rejection after data already went out must flush the FIFOs.
        if (fail) begin
            err_d    = 1'b1;
            code_d   = fail_code;
            state_d  = ST_IDLE;
            rc_clr   = 1'b1;
            pushed_d = 1'b0;
            if (pushed_q) begin
                clr_d    = 1'b1;
                mat_ld_d = 1'b0;
                vec_ld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            cmd_q    <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            n_q      <= 4'd4;
            n_pend_q <= 4'd4;
            data_q   <= '0;
            mat_q    <= '0;
            vec_q    <= 1'b0;
            clr_q    <= 1'b0;
            start_q  <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_LEN;
            mat_ld_q <= 1'b0;
            vec_ld_q <= 1'b0;
            pushed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cmd_q    <= cmd_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            n_q      <= n_d;
            n_pend_q <= n_pend_d;
            data_q   <= data_d;
            mat_q    <= mat_d;
            vec_q    <= vec_d;
            clr_q    <= clr_d;
            start_q  <= start_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            code_q   <= code_d;
            mat_ld_q <= mat_ld_d;
            vec_ld_q <= vec_ld_d;
            pushed_q <= pushed_d;
        end
    end

    assign bus.n_cfg     = n_q;
    assign bus.push_data = data_q;
    assign bus.mat_push  = mat_q;
    assign bus.vec_push  = vec_q;
    assign bus.fifo_clr  = clr_q;
    assign bus.start     = start_q;
    assign bus.frame_ok  = ok_q;
    assign bus.err       = err_q;
    assign bus.err_code  = code_q;
endmodule

// File: tb/tb_cmd_frame_loader.sv
// Directed bench for cmd_frame_loader: byte-by-byte table of expected
// registered outputs, plus hand sequences for timeout and mid-frame reset.
module tb_cmd_frame_loader;
    localparam int MAX_N   = 8;
    localparam int DW      = 8;
    localparam int TIMEOUT = 40;

    typedef struct packed {
        logic [7:0] mat_push;
        logic       vec_push;
        logic [7:0] push_data;
        logic       fifo_clr;
        logic       start;
        logic       frame_ok;
        logic       err;
        logic [1:0] err_code;
        logic [3:0] n_cfg;
    } obs_t;

    typedef struct {
        logic [7:0] b;
        logic       busy;
        obs_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cmd_frame_loader_if #(.MAX_N(MAX_N), .DW(DW)) bus ();

    cmd_frame_loader #(.MAX_N(MAX_N), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    vec_t       tbl[$];
    logic [1:0] cur_code = 2'd0;
    logic [3:0] cur_n    = 4'd4;
    logic       cur_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.mat_push  = bus.mat_push;
        o.vec_push  = bus.vec_push;
        o.push_data = bus.push_data;
        o.fifo_clr  = bus.fifo_clr;
        o.start     = bus.start;
        o.frame_ok  = bus.frame_ok;
        o.err       = bus.err;
        o.err_code  = bus.err_code;
        o.n_cfg     = bus.n_cfg;
        return o;
    endfunction

    function automatic obs_t mk(input logic [7:0] m, input logic v, input logic [7:0] d,
                                input logic clr, input logic st, input logic ok, input logic e);
        obs_t o;
        o.mat_push  = m;
        o.vec_push  = v;
        o.push_data = d;
        o.fifo_clr  = clr;
        o.start     = st;
        o.frame_ok  = ok;
        o.err       = e;
        o.err_code  = cur_code;
        o.n_cfg     = cur_n;
        return o;
    endfunction

    task automatic add(input logic [7:0] b, input obs_t e);
        vec_t v;
        v.b = b; v.busy = cur_busy; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic t_quiet(input logic [7:0] b); add(b, mk(8'h00, 0, 8'h00, 0, 0, 0, 0)); endtask
    task automatic t_mat(input logic [7:0] b, input logic [7:0] m); add(b, mk(m, 0, b, 0, 0, 0, 0)); endtask
    task automatic t_vec(input logic [7:0] b); add(b, mk(8'h00, 1, b, 0, 0, 0, 0)); endtask
    task automatic t_ok(input logic [7:0] b); add(b, mk(8'h00, 0, 8'h00, 0, 0, 1, 0)); endtask
    task automatic t_start(input logic [7:0] b); add(b, mk(8'h00, 0, 8'h00, 0, 1, 1, 0)); endtask
    task automatic t_err(input logic [7:0] b, input logic [1:0] code, input logic clr);
        cur_code = code;
        add(b, mk(8'h00, 0, 8'h00, clr, 0, 0, 1));
    endtask

    // One strobe; outputs checked one edge later, pulses checked gone one edge after that.
    task automatic apply_vec(input vec_t v, input string tag);
        obs_t quiet;
        @(negedge clk);
        bus.busy     = v.busy;
        bus.rx_data  = v.b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        check(tag, 32'(sample()), 32'(v.exp));
        quiet = v.exp;
        quiet.mat_push = '0; quiet.vec_push = 1'b0; quiet.push_data = '0;
        quiet.fifo_clr = 1'b0; quiet.start = 1'b0; quiet.frame_ok = 1'b0; quiet.err = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_off"}, 32'(sample()), 32'(quiet));
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) apply_vec(tbl[i], $sformatf("%s_%0d_b%h", tag, i, tbl[i].b));
        tbl.delete();
    endtask

    initial begin
        int waited;
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.busy     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(sample()), 32'(mk(8'h00, 0, 8'h00, 0, 0, 0, 0)));
        @(negedge clk);
        rst = 1'b1;

        // Junk before header, then set N=3 and an unloaded start.
        t_quiet(8'h55);
        t_quiet(8'hFE); t_quiet(8'h02); t_quiet(8'h01); t_quiet(8'h03);
        cur_n = 4'd3; t_ok(8'hEF);
        t_quiet(8'hFE); t_quiet(8'h01); t_quiet(8'h03); t_err(8'hEF, 2'd3, 1'b0);
        // N=3 matrix: rows land in FIFOs 0,1,2.
        t_quiet(8'hFE); t_quiet(8'h0A); t_quiet(8'h04);
        for (int i = 1; i <= 9; i++) t_mat(8'(i), 8'(1 << ((i - 1) / 3)));
        t_ok(8'hEF);
        // Vector, start accepted, second start rejected.
        t_quiet(8'hFE); t_quiet(8'h04); t_quiet(8'h02);
        t_vec(8'h07); t_vec(8'h08); t_vec(8'h09); t_ok(8'hEF);
        t_quiet(8'hFE); t_quiet(8'h01); t_quiet(8'h03); t_start(8'hEF);
        t_quiet(8'hFE); t_quiet(8'h01); t_quiet(8'h03); t_err(8'hEF, 2'd3, 1'b0);
        // Unknown command, length mismatch, busy at command byte.
        t_quiet(8'hFE); t_quiet(8'h01); t_err(8'h07, 2'd1, 1'b0); t_quiet(8'hEF);
        t_quiet(8'hFE); t_quiet(8'h03); t_err(8'h03, 2'd0, 1'b0); t_quiet(8'hEF);
        cur_busy = 1'b1;
        t_quiet(8'hFE); t_quiet(8'h01); t_err(8'h03, 2'd3, 1'b0);
        cur_busy = 1'b0;
        t_quiet(8'hEF);
        // N range boundaries: 9 and 1 rejected, 8 accepted, then N=2.
        t_quiet(8'hFE); t_quiet(8'h02); t_quiet(8'h01); t_err(8'h09, 2'd0, 1'b0); t_quiet(8'hEF);
        t_quiet(8'hFE); t_quiet(8'h02); t_quiet(8'h01); t_err(8'h01, 2'd0, 1'b0); t_quiet(8'hEF);
        t_quiet(8'hFE); t_quiet(8'h02); t_quiet(8'h01); t_quiet(8'h08); cur_n = 4'd8; t_ok(8'hEF);
        t_quiet(8'hFE); t_quiet(8'h02); t_quiet(8'h01); t_quiet(8'h02); cur_n = 4'd2; t_ok(8'hEF);
        // Bad tail on matrix flushes FIFOs.
        t_quiet(8'hFE); t_quiet(8'h05); t_quiet(8'h04);
        t_mat(8'h01, 8'h01); t_mat(8'h02, 8'h01); t_mat(8'h03, 8'h02); t_mat(8'h04, 8'h02);
        t_err(8'hEE, 2'd2, 1'b1);
        // Good matrix, bad vector tail clears both flags, so start is refused.
        t_quiet(8'hFE); t_quiet(8'h05); t_quiet(8'h04);
        t_mat(8'h11, 8'h01); t_mat(8'h12, 8'h01); t_mat(8'h13, 8'h02); t_mat(8'h14, 8'h02);
        t_ok(8'hEF);
        t_quiet(8'hFE); t_quiet(8'h03); t_quiet(8'h02); t_vec(8'h0A); t_vec(8'h0B);
        t_err(8'hEE, 2'd2, 1'b1);
        t_quiet(8'hFE); t_quiet(8'h03); t_quiet(8'h02); t_vec(8'h0C); t_vec(8'h0D); t_ok(8'hEF);
        t_quiet(8'hFE); t_quiet(8'h01); t_quiet(8'h03); t_err(8'hEF, 2'd3, 1'b0);
        run_table("main");

        // Timeout mid-matrix: err + fifo_clr exactly TIMEOUT clocks after the last byte.
        t_quiet(8'hFE); t_quiet(8'h05); t_quiet(8'h04);
        run_table("tmo_hdr");
        @(negedge clk);
        bus.rx_data  = 8'h01;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        check("tmo_push", 32'(sample()), 32'(mk(8'h01, 0, 8'h01, 0, 0, 0, 0)));
        waited = 0;
        while (waited <= TIMEOUT + 10) begin
            @(posedge clk);
            #1;
            waited++;
            if (bus.err) break;
        end
        check("tmo_cycles", 32'(waited), 32'(TIMEOUT));
        cur_code = 2'd2;
        check("tmo_err", 32'(sample()), 32'(mk(8'h00, 0, 8'h00, 1, 0, 0, 1)));
        repeat (2) @(posedge clk);

        // Next frame after timeout parses normally.
        t_quiet(8'hFE); t_quiet(8'h05); t_quiet(8'h04);
        t_mat(8'h21, 8'h01); t_mat(8'h22, 8'h01); t_mat(8'h23, 8'h02); t_mat(8'h24, 8'h02);
        t_ok(8'hEF);
        run_table("post_tmo");

        // Reset in the middle of the payload, while a push pulse is high.
        t_quiet(8'hFE); t_quiet(8'h05); t_quiet(8'h04);
        run_table("rst_hdr");
        @(negedge clk);
        bus.rx_data  = 8'h31;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        check("rst_push", 32'(sample()), 32'(mk(8'h01, 0, 8'h31, 0, 0, 0, 0)));
        #2;
        rst = 1'b0;
        #1;
        cur_code = 2'd0;
        cur_n    = 4'd4;
        check("rst_async", 32'(sample()), 32'(mk(8'h00, 0, 8'h00, 0, 0, 0, 0)));
        @(negedge clk);
        rst = 1'b1;
        t_quiet(8'hFE); t_quiet(8'h02); t_quiet(8'h01); t_quiet(8'h05);
        cur_n = 4'd5; t_ok(8'hEF);
        run_table("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
